// File: rtl/param_stack.sv
// Parametrised LIFO stack: registered pop data with valid strobe, count, full/empty and sticky error flags.
// Optional peek outputs (top, top_valid) are added when PARAM_STACK_PEEK_EN is defined.
module param_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
`ifdef PARAM_STACK_PEEK_EN
  output logic [DATA_W-1:0] top,
  output logic              top_valid,
`endif
  output logic              underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0] countM1;
  logic [AW-1:0]    topIdx;
  logic [AW-1:0]    pushIdx;
  logic             wrEn;
  logic [AW-1:0]    wrIdx;

  assign countM1 = count - ONE_C;
  assign topIdx  = countM1[AW-1:0];
  assign pushIdx = count[AW-1:0];

  // A plain push writes above the top; push+pop on a non-empty stack overwrites the top in place.
  always_comb begin
    wrEn  = 1'b0;
    wrIdx = pushIdx;
    if (push && !pop && !full) begin
      wrEn  = 1'b1;
      wrIdx = pushIdx;
    end else if (push && pop && !empty) begin
      wrEn  = 1'b1;
      wrIdx = topIdx;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrIdx] <= din;
    end
  end

  // Error clear is applied first so that a same-cycle rejection below still sets the flag.
  always_ff @(posedge clk) begin
    if (Reset) begin
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (err_clr) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (push && pop) begin
        dout_valid <= 1'b1;
        if (empty) begin
          dout <= din;
        end else begin
          dout <= mem[topIdx];
        end
      end else if (push) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          count <= count + ONE_C;
          empty <= 1'b0;
          full  <= (count == LAST_C);
        end
      end else if (pop) begin
        if (empty) begin
          underflow <= 1'b1;
        end else begin
          dout       <= mem[topIdx];
          dout_valid <= 1'b1;
          count      <= countM1;
          full       <= 1'b0;
          empty      <= (count == ONE_C);
        end
      end
    end
  end

`ifdef PARAM_STACK_PEEK_EN
  assign top       = empty ? '0 : mem[topIdx];
  assign top_valid = !empty;
`endif

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO stack with synchronous push/pop, registered pop data with valid strobe, occupancy count, full/empty status and sticky overflow/underflow error flags.
- Next-generation replacement for the fixed 8-bit x 256 stack used by the CPU datapath for call/return and operand save/restore.
- Adds defined simultaneous push+pop, error reporting and configurable width/depth.

Parameters:
- DATA_W, 8, width of each stack entry in bits.
- DEPTH, 256, number of entries; any integer >= 2, not restricted to powers of two.
- CNT_W, $clog2(DEPTH+1), localparam; width of the count output.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- push  input  1  push din onto stack this cycle.
- pop  input  1  pop top entry this cycle.
- din  input  DATA_W  push data.
- err_clr  input  1  clears sticky overflow/underflow flags.
- dout  output  DATA_W  registered pop data.
- dout_valid  output  1  one-cycle strobe; dout holds a popped value.
- count  output  CNT_W  current number of entries, 0..DEPTH.
- empty  output  1  count == 0, registered.
- full  output  1  count == DEPTH, registered.
- overflow  output  1  sticky; a push was rejected because the stack was full.
- underflow  output  1  sticky; a pop was rejected because the stack was empty.

Behaviour:
- Reset, synchronous and priority over everything:
  - count=0, empty=1, full=0, dout=0, dout_valid=0, overflow=0, underflow=0.
  - Memory contents are NOT cleared and are undefined after reset.
- Storage: DEPTH x DATA_W array. Stack pointer sp = count; the top entry is mem[count-1].
- Evaluation uses state at the clock edge. Exactly one case applies:
  - Idle (no push, no pop): state unchanged, dout holds its last value, dout_valid=0.
  - Push only, not full: mem[count] <= din; count += 1.
  - Push only, full: no write, count unchanged, overflow <= 1.
  - Pop only, not empty: dout <= mem[count-1]; dout_valid <= 1 next cycle (1-cycle latency); count -= 1.
  - Pop only, empty: dout unchanged, dout_valid=0, underflow <= 1.
  - Push+pop, not empty (including full): replace top.
    - dout <= old mem[count-1], dout_valid <= 1.
    - mem[count-1] <= din.
    - count unchanged; no overflow flag, even when full.
  - Push+pop, empty: bypass. dout <= din, dout_valid <= 1, count stays 0, no underflow.
- dout_valid is high for exactly one cycle per accepted pop.
- empty and full are registered and update in the same cycle as count.
- Sticky flags:
  - Set on the rejected operation.
  - Cleared by err_clr. If set and clear occur in the same cycle, set wins.
  - Only Reset and err_clr clear them.
- Rejected operations never corrupt memory or count.
- Pointer never wraps; count saturates logically at 0 and DEPTH.

Optional Feature:
- Macro: PARAM_STACK_PEEK_EN.
- Defined: adds two output ports.
  - top (DATA_W): combinational mem[count-1].
  - top_valid (1): equals !empty.
  - top is 0 when empty. Peek does not alter state.
- Not defined: neither port exists. All other behaviour is identical.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then pop three times -> dout 0x33, 0x22, 0x11, each with a one-cycle dout_valid one cycle after its pop; count 3->0; empty=1 at end.
- DEPTH=4: push 5 values 0xA0..0xA4 -> count=4, full=1, overflow=1 after the fifth push; pop four -> 0xA3, 0xA2, 0xA1, 0xA0.
- Pop on empty -> underflow=1, dout_valid=0, count=0; assert err_clr -> underflow=0 next cycle; err_clr together with another empty pop -> underflow stays 1.
- Push 0x55, then push+pop with din=0x66 -> dout=0x55 valid, count stays 1; pop -> dout=0x66. Push+pop on empty with din=0x77 -> dout=0x77 valid, count=0, no underflow.
- Reset asserted mid-sequence with count=3 and a pop in flight -> next cycle count=0, empty=1, dout=0, dout_valid=0, both flags 0.
- With PARAM_STACK_PEEK_EN defined: push 0x12, 0x34 -> top=0x34, top_valid=1 with no pop issued; pop twice -> top_valid=0, top=0.
